// File: rtl/riscv_regfile_pkg.sv
// Shared types and defaults for the multi-port integer register file.
// Bypass is enabled by defining RISCV_REGFILE_BYPASS_EN.
package riscv_regfile_pkg;

    typedef enum logic {
        INIT,
        RUN
    } regfile_state_e;

    localparam int DEF_WORD_LENGTH = 32;
    localparam int DEF_ADDR_LENGTH = 5;
    localparam int DEF_NUM_REGS    = 32;
    localparam int DEF_NUM_READ    = 2;
    localparam int DEF_NUM_WRITE   = 1;
    localparam int MAX_PORTS       = 32;

    // Highest-index set bit of a write-port match mask
    function automatic int hi_port(input logic [MAX_PORTS-1:0] hit);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (hit[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/riscv_regfile_scoreboard.sv
// Busy scoreboard: reserve sets, valid write clears, set wins on collision.
// Honours RISCV_REGFILE_BYPASS_EN for the read_busy lookup.
module riscv_regfile_scoreboard
    import riscv_regfile_pkg::*;
#(
    parameter int ADDR_LENGTH = DEF_ADDR_LENGTH,
    parameter int NUM_REGS    = DEF_NUM_REGS,
    parameter int NUM_READ    = DEF_NUM_READ
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            run,
    input  logic [NUM_REGS-1:0]             clr,
    input  logic                            reserve_en,
    input  logic [ADDR_LENGTH-1:0]          reserve_addr,
    input  logic [NUM_READ*ADDR_LENGTH-1:0] read_addr,
    output logic [NUM_REGS-1:0]             busy,
    output logic [NUM_READ-1:0]             read_busy
);

    localparam logic [ADDR_LENGTH:0] NREGS = (ADDR_LENGTH+1)'(NUM_REGS);

    logic [NUM_REGS-1:0] set;

    always_comb begin
        set = '0;
        if (run && reserve_en && reserve_addr != '0 &&
            {1'b0, reserve_addr} < NREGS) begin
            set[reserve_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~clr) | set;
        end
    end

    always_comb begin
        read_busy = '0;
        for (int j = 0; j < NUM_READ; j++) begin
            if (run && {1'b0, read_addr[j*ADDR_LENGTH +: ADDR_LENGTH]} < NREGS) begin
`ifdef RISCV_REGFILE_BYPASS_EN
                // A same-cycle write retires the old producer; only a new reserve keeps it busy
                read_busy[j] = clr[read_addr[j*ADDR_LENGTH +: ADDR_LENGTH]]
                             ? set[read_addr[j*ADDR_LENGTH +: ADDR_LENGTH]]
                             : busy[read_addr[j*ADDR_LENGTH +: ADDR_LENGTH]];
`else
                read_busy[j] = busy[read_addr[j*ADDR_LENGTH +: ADDR_LENGTH]];
`endif
            end
        end
    end

endmodule

// File: rtl/riscv_regfile_mp.sv
// Multi-port integer register file with post-reset zeroing and busy scoreboard.
// Define RISCV_REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module riscv_regfile_mp
    import riscv_regfile_pkg::*;
#(
    parameter int WORD_LENGTH = DEF_WORD_LENGTH,
    parameter int ADDR_LENGTH = DEF_ADDR_LENGTH,
    parameter int NUM_REGS    = DEF_NUM_REGS,
    parameter int NUM_READ    = DEF_NUM_READ,
    parameter int NUM_WRITE   = DEF_NUM_WRITE
) (
    input  logic                              clk,
    input  logic                              rst_n,
    output logic                              ready,
    input  logic [NUM_READ*ADDR_LENGTH-1:0]   read_addr,
    output logic [NUM_READ*WORD_LENGTH-1:0]   read_data,
    output logic [NUM_READ-1:0]               read_busy,
    input  logic [NUM_WRITE-1:0]              write_en,
    input  logic [NUM_WRITE*ADDR_LENGTH-1:0]  write_addr,
    input  logic [NUM_WRITE*WORD_LENGTH-1:0]  write_data,
    input  logic                              reserve_en,
    input  logic [ADDR_LENGTH-1:0]            reserve_addr,
    output logic [NUM_REGS-1:0]               busy
);

    localparam logic [ADDR_LENGTH:0] NREGS = (ADDR_LENGTH+1)'(NUM_REGS);
    localparam logic [ADDR_LENGTH-1:0] LAST = ADDR_LENGTH'(NUM_REGS-1);

    regfile_state_e         state, state_nx;
    logic [ADDR_LENGTH-1:0] init_cnt;
    logic [WORD_LENGTH-1:0] regs [NUM_REGS];
    logic                   run;
    logic [NUM_WRITE-1:0]   wr_ok;
    logic [NUM_REGS-1:0]    clr;

    assign run   = (state == RUN);
    assign ready = run;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == INIT) init_cnt <= init_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            INIT:    if (init_cnt == LAST) state_nx = RUN;
            RUN:     state_nx = RUN;
            default: state_nx = INIT;
        endcase
    end

    always_comb begin
        wr_ok = '0;
        clr   = '0;
        for (int i = 0; i < NUM_WRITE; i++) begin
            if (run && write_en[i] &&
                write_addr[i*ADDR_LENGTH +: ADDR_LENGTH] != '0 &&
                {1'b0, write_addr[i*ADDR_LENGTH +: ADDR_LENGTH]} < NREGS) begin
                wr_ok[i] = 1'b1;
                clr[write_addr[i*ADDR_LENGTH +: ADDR_LENGTH]] = 1'b1;
            end
        end
    end

    // Later ports overwrite earlier ones, so the highest index wins
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == INIT) begin
                regs[init_cnt] <= '0;
            end else begin
                for (int i = 0; i < NUM_WRITE; i++) begin
                    if (wr_ok[i]) begin
                        regs[write_addr[i*ADDR_LENGTH +: ADDR_LENGTH]] <=
                            write_data[i*WORD_LENGTH +: WORD_LENGTH];
                    end
                end
            end
        end
    end

`ifdef RISCV_REGFILE_BYPASS_EN
    logic [MAX_PORTS-1:0] hit;
`endif

    always_comb begin
        read_data = '0;
`ifdef RISCV_REGFILE_BYPASS_EN
        hit = '0;
`endif
        for (int j = 0; j < NUM_READ; j++) begin
            if (run && read_addr[j*ADDR_LENGTH +: ADDR_LENGTH] != '0 &&
                {1'b0, read_addr[j*ADDR_LENGTH +: ADDR_LENGTH]} < NREGS) begin
                read_data[j*WORD_LENGTH +: WORD_LENGTH] =
                    regs[read_addr[j*ADDR_LENGTH +: ADDR_LENGTH]];
`ifdef RISCV_REGFILE_BYPASS_EN
                hit = '0;
                for (int i = 0; i < NUM_WRITE; i++) begin
                    hit[i] = wr_ok[i] &&
                        write_addr[i*ADDR_LENGTH +: ADDR_LENGTH] ==
                        read_addr[j*ADDR_LENGTH +: ADDR_LENGTH];
                end
                if (|hit) begin
                    read_data[j*WORD_LENGTH +: WORD_LENGTH] =
                        write_data[hi_port(hit)*WORD_LENGTH +: WORD_LENGTH];
                end
`endif
            end
        end
    end

    riscv_regfile_scoreboard #(
        .ADDR_LENGTH (ADDR_LENGTH),
        .NUM_REGS    (NUM_REGS),
        .NUM_READ    (NUM_READ)
    ) u_sb (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .clr          (clr),
        .reserve_en   (reserve_en),
        .reserve_addr (reserve_addr),
        .read_addr    (read_addr),
        .busy         (busy),
        .read_busy    (read_busy)
    );

endmodule

// File: tb/tb_riscv_regfile_mp.sv
// Directed bench for riscv_regfile_mp with two write ports.
// Expectations follow RISCV_REGFILE_BYPASS_EN when it is defined.
module tb_riscv_regfile_mp;

    localparam int W  = 32;
    localparam int A  = 5;
    localparam int NR = 32;
    localparam int RD = 2;
    localparam int WR = 2;

`ifdef RISCV_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            ready;
    logic [RD*A-1:0] read_addr;
    logic [RD*W-1:0] read_data;
    logic [RD-1:0]   read_busy;
    logic [WR-1:0]   write_en;
    logic [WR*A-1:0] write_addr;
    logic [WR*W-1:0] write_data;
    logic            reserve_en;
    logic [A-1:0]    reserve_addr;
    logic [NR-1:0]   busy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    riscv_regfile_mp #(
        .WORD_LENGTH (W),
        .ADDR_LENGTH (A),
        .NUM_REGS    (NR),
        .NUM_READ    (RD),
        .NUM_WRITE   (WR)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ready        (ready),
        .read_addr    (read_addr),
        .read_data    (read_data),
        .read_busy    (read_busy),
        .write_en     (write_en),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .reserve_en   (reserve_en),
        .reserve_addr (reserve_addr),
        .busy         (busy)
    );

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        re;
        logic [4:0]  rsa;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] ed0;
        logic [31:0] ed1;
        logic [1:0]  eb;
        logic [31:0] ebusy;
    } vec_t;

    vec_t vt [8];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        write_en     = '0;
        write_addr   = '0;
        write_data   = '0;
        reserve_en   = 1'b0;
        reserve_addr = '0;
        read_addr    = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            chk({tag, " init flags"}, {31'b0, ready, read_busy, busy}, '0);
            chk({tag, " init data"}, read_data, '0);
            tick();
            n++;
        end
        chk({tag, " ready edges"}, 64'(n), 64'd32);
    endtask

    initial begin
        vt[0] = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 5'd0,
                  5'd1, 5'd2, 32'h0, 32'h0, 2'b00, 32'h0};
        vt[1] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0,
                  5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 32'h0};
        vt[2] = '{2'b11, 5'd0, 32'h1, 5'd6, 32'h12345678, 1'b0, 5'd0,
                  5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 2'b00, 32'h0};
        vt[3] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0,
                  5'd0, 5'd6, 32'h0, 32'h12345678, 2'b00, 32'h0};
        vt[4] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9,
                  5'd9, 5'd6, 32'h0, 32'h12345678, 2'b00, 32'h0};
        vt[5] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd0,
                  5'd9, 5'd0, 32'h0, 32'h0, 2'b01, 32'h200};
        vt[6] = '{2'b10, 5'd0, 32'h0, 5'd31, 32'hA5A5A5A5, 1'b0, 5'd0,
                  5'd0, 5'd9, 32'h0, 32'h0, 2'b10, 32'h200};
        vt[7] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0,
                  5'd31, 5'd9, 32'hA5A5A5A5, 32'h0, 2'b10, 32'h200};

        idle();
        rst_n = 1'b0;
        repeat (3) tick();
        chk("reset ready/busy", {31'b0, ready, busy}, '0);
        rst_n = 1'b1;
        wait_ready("boot");

        for (int i = 0; i < NR; i += 2) begin
            read_addr = {5'(i + 1), 5'(i)};
            #1;
            chk($sformatf("zero x%0d/x%0d", i, i + 1), read_data, '0);
        end
        chk("boot busy", 64'(busy), '0);

        for (int i = 0; i < 8; i++) begin
            write_en     = vt[i].we;
            write_addr   = {vt[i].wa1, vt[i].wa0};
            write_data   = {vt[i].wd1, vt[i].wd0};
            reserve_en   = vt[i].re;
            reserve_addr = vt[i].rsa;
            read_addr    = {vt[i].ra1, vt[i].ra0};
            @(negedge clk);
            chk($sformatf("row%0d data", i), read_data, {vt[i].ed1, vt[i].ed0});
            chk($sformatf("row%0d rbusy", i), 64'(read_busy), 64'(vt[i].eb));
            chk($sformatf("row%0d busy", i), 64'(busy), 64'(vt[i].ebusy));
            tick();
        end
        idle();

        // Same-address writes on both ports
        write_en = 2'b01;
        write_addr = {5'd0, 5'd7};
        write_data = {32'h0, 32'h33};
        tick();
        write_en = 2'b11;
        write_addr = {5'd7, 5'd7};
        write_data = {32'h22, 32'h11};
        read_addr = {5'd7, 5'd7};
        @(negedge clk);
        chk("x7 same-cycle", read_data,
            BYP ? {32'h22, 32'h22} : {32'h33, 32'h33});
        tick();
        idle();
        read_addr = {5'd7, 5'd7};
        @(negedge clk);
        chk("x7 after dual write", read_data, {32'h22, 32'h22});
        tick();

        // Scoreboard: set wins over clear, then clear alone
        write_en = 2'b01;
        write_addr = {5'd0, 5'd9};
        write_data = {32'h0, 32'hAB};
        reserve_en = 1'b1;
        reserve_addr = 5'd9;
        read_addr = {5'd0, 5'd9};
        @(negedge clk);
        chk("x9 rbusy w+r", 64'(read_busy), 64'd1);
        tick();
        reserve_en = 1'b0;
        write_data = {32'h0, 32'hCD};
        @(negedge clk);
        chk("busy9 held", 64'(busy), 64'h200);
        chk("x9 rbusy write", 64'(read_busy), BYP ? 64'd0 : 64'd1);
        chk("x9 data write", 64'(read_data[31:0]),
            BYP ? 64'hCD : 64'hAB);
        tick();
        idle();
        read_addr = {5'd0, 5'd9};
        @(negedge clk);
        chk("busy9 released", 64'(busy), '0);
        chk("x9 rbusy idle", 64'(read_busy), '0);
        chk("x9 data idle", 64'(read_data[31:0]), 64'hCD);
        tick();

        // Mid-run reset, with writes and reserves attempted during init
        write_en = 2'b01;
        write_addr = {5'd0, 5'd3};
        write_data = {32'h0, 32'h55};
        reserve_en = 1'b1;
        reserve_addr = 5'd4;
        tick();
        idle();
        read_addr = {5'd4, 5'd3};
        @(negedge clk);
        chk("x3 before reset", 64'(read_data[31:0]), 64'h55);
        chk("x4 busy before reset", {30'b0, read_busy, busy}, {30'b0, 2'b10, 32'h10});
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        write_en = 2'b11;
        write_addr = {5'd12, 5'd10};
        write_data = {32'h99, 32'h77};
        reserve_en = 1'b1;
        reserve_addr = 5'd11;
        read_addr = {5'd10, 5'd3};
        wait_ready("rerun");
        idle();
        read_addr = {5'd10, 5'd3};
        @(negedge clk);
        chk("x3/x10 after rerun", read_data, '0);
        chk("busy after rerun", {31'b0, ready, busy}, 64'h1_0000_0000);
        read_addr = {5'd11, 5'd12};
        #1;
        chk("x12/x11 after rerun", {30'b0, read_busy, read_data[31:0]}, '0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
